// File: rtl/word_byte_serializer.sv
// Splits DATA_WIDTH-bit words into a valid/ready byte stream, LSB- or MSB-lane first.
// Define WORD_SER_PREFETCH_EN to add a one-word prefetch buffer for gap-free back-to-back words.
module word_byte_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic [DATA_WIDTH-1:0] word_in,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [7:0]            byte_out,
  output logic [SEL_W-1:0]      byte_sel,
  output logic                  byte_last,
  output logic                  busy
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [SEL_W-1:0] FIRST_LANE = MSB_FIRST ? SEL_W'(NUM_BYTES - 1) : SEL_W'(0);
  localparam logic [SEL_W-1:0] LAST_LANE  = MSB_FIRST ? SEL_W'(0) : SEL_W'(NUM_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [7:0]              byte_out_q, byte_out_d;
  logic                    byte_valid_q, byte_valid_d;
  logic                    byte_last_q, byte_last_d;
  logic                    busy_q, busy_d;
  logic                    word_ready_q, word_ready_d;
`ifdef WORD_SER_PREFETCH_EN
  logic [DATA_WIDTH-1:0]   buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
`endif

  logic word_xfer;
  logic byte_xfer;

  assign word_xfer = word_valid & word_ready_q;
  assign byte_xfer = byte_valid_q & byte_ready;

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    sel_d        = sel_q;
    byte_valid_d = byte_valid_q;
    byte_last_d  = byte_last_q;
`ifdef WORD_SER_PREFETCH_EN
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (word_xfer) begin
          word_d       = word_in;
          sel_d        = FIRST_LANE;
          state_d      = SEND;
          byte_valid_d = 1'b1;
          byte_last_d  = 1'b0;
        end
      end
      SEND: begin
        if (byte_xfer) begin
          if (!byte_last_q) begin
            sel_d       = MSB_FIRST ? sel_q - 1'b1 : sel_q + 1'b1;
            byte_last_d = (sel_d == LAST_LANE);
          end else begin
`ifdef WORD_SER_PREFETCH_EN
            // Buffered word has priority; a same-cycle word can only arrive when the buffer is empty.
            if (buf_full_q) begin
              word_d      = buf_q;
              buf_full_d  = 1'b0;
              sel_d       = FIRST_LANE;
              byte_last_d = 1'b0;
            end else if (word_xfer) begin
              word_d      = word_in;
              sel_d       = FIRST_LANE;
              byte_last_d = 1'b0;
            end else begin
              state_d      = IDLE;
              byte_valid_d = 1'b0;
              byte_last_d  = 1'b0;
            end
`else
            state_d      = IDLE;
            byte_valid_d = 1'b0;
            byte_last_d  = 1'b0;
`endif
          end
        end
`ifdef WORD_SER_PREFETCH_EN
        if (word_xfer && !(byte_xfer && byte_last_q)) begin
          buf_d      = word_in;
          buf_full_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

`ifdef WORD_SER_PREFETCH_EN
    word_ready_d = !buf_full_d;
`else
    word_ready_d = (state_d == IDLE);
`endif
    busy_d = (state_d == SEND);

    byte_out_d = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (sel_d == SEL_W'(i)) byte_out_d = word_d[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      sel_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      word_ready_q <= 1'b1;
`ifdef WORD_SER_PREFETCH_EN
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      sel_q        <= sel_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      busy_q       <= busy_d;
      word_ready_q <= word_ready_d;
`ifdef WORD_SER_PREFETCH_EN
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
`endif
    end
  end

  assign word_ready = word_ready_q;
  assign byte_valid = byte_valid_q;
  assign byte_out   = byte_out_q;
  assign byte_sel   = sel_q;
  assign byte_last  = byte_last_q;
  assign busy       = busy_q;

endmodule
